// File: rtl/sprite_rom_arbiter.sv
// Sprite ROM arbiter: shares one synchronous ROM among NUM_REQ readers, display port 0 first,
// game ports round-robin with a starvation override; returned data is tagged back to its issuer.
module sprite_rom_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 4,
    parameter int ROM_LAT    = 1,
    parameter int STARVE_MAX = 16
) (
    input  logic                      vga_clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rd_valid,
    output logic [DATA_W-1:0]         rd_data,
    output logic [ADDR_W-1:0]         rom_address,
    input  logic [DATA_W-1:0]         rom_q
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [PTR_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]   starve_cnt;
    logic [PTR_W-1:0]   rr_port;
    logic               rr_hit;
    logic               rr_win;
    logic               lower_req;
    logic               override;
    logic [ADDR_W-1:0]  win_addr;
    logic [NUM_REQ-1:0] vld_p [ROM_LAT+1];

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1'b1;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] k);
        return (k == PTR_W'(NUM_REQ - 1)) ? PTR_W'(1) : k + 1'b1;
    endfunction

    assign lower_req = |req[NUM_REQ-1:1];
    assign override  = (STARVE_MAX > 0) && (starve_cnt == CNT_MAX) && lower_req;

    // Round-robin search over ports 1..NUM_REQ-1 starting at rr_ptr
    always_comb begin
        int idx;
        idx     = 0;
        rr_hit  = 1'b0;
        rr_port = '0;
        for (int j = 0; j < NUM_REQ - 1; j++) begin
            idx = int'(rr_ptr) + j;
            if (idx >= NUM_REQ) idx = idx - (NUM_REQ - 1);
            if (!rr_hit && req[idx]) begin
                rr_hit  = 1'b1;
                rr_port = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        gnt    = '0;
        rr_win = 1'b0;
        if (override) begin
            gnt[rr_port] = 1'b1;
            rr_win       = 1'b1;
        end else if (req[0]) begin
            gnt[0] = 1'b1;
        end else if (rr_hit) begin
            gnt[rr_port] = 1'b1;
            rr_win       = 1'b1;
        end
    end

    always_comb begin
        win_addr = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (gnt[i]) win_addr = addr[i*ADDR_W +: ADDR_W];
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            rr_ptr     <= PTR_W'(1);
            starve_cnt <= '0;
        end else begin
            if (rr_win)
                rr_ptr <= ptr_next(rr_port);
            if (rr_win || !lower_req)
                starve_cnt <= '0;
            else if (gnt[0])
                starve_cnt <= sat_inc(starve_cnt);
        end
    end

    // Stage p0: issue winning address to the ROM
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset)
            rom_address <= '0;
        else if (|gnt)
            rom_address <= win_addr;
    end

    // Stages p0..pROM_LAT: grant vector follows the read through the ROM
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s <= ROM_LAT; s++) vld_p[s] <= '0;
        end else begin
            vld_p[0] <= gnt;
            for (int s = 1; s <= ROM_LAT; s++) vld_p[s] <= vld_p[s-1];
        end
    end

    assign rd_valid = vld_p[ROM_LAT];
    assign rd_data  = rom_q;

endmodule
